// File: rtl/wb_regfile.sv
// Write-back select and 32-entry register file with two combinational read ports
// and a commit counter. Define WB_BYPASS_EN to forward same-cycle commits to reads.
module wb_regfile #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] Dataout,
  input  logic [WIDTH-1:0] ALUout,
  input  logic [4:0]       Rw,
  input  logic             MemtoReg,
  input  logic             RegWr,
  input  logic [4:0]       Ra,
  input  logic [4:0]       Rb,
  output logic [WIDTH-1:0] busA,
  output logic [WIDTH-1:0] busB,
  output logic [WIDTH-1:0] busW,
  output logic [31:0]      WrCount
);

  logic [WIDTH-1:0] regs [NREG];
  logic [31:0]      wr_count_reg;
  logic             commit;
  logic [4:0]       rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  assign busW    = MemtoReg ? Dataout : ALUout;
  assign commit  = RegWr && (Rw != 5'd0);
  assign WrCount = wr_count_reg;

  // Entry 0 is cleared on reset and never written, since commit excludes Rw == 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      wr_count_reg <= '0;
    end else if (commit) begin
      regs[Rw]     <= busW;
      wr_count_reg <= wr_count_reg + 32'd1;
    end
  end

  assign rd_addr[0] = Ra;
  assign rd_addr[1] = Rb;
  assign busA       = rd_data[0];
  assign busB       = rd_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = regs[rd_addr[gi]];
        if (rd_addr[gi] == 5'd0) rd_data[gi] = '0;
`ifdef WB_BYPASS_EN
        // Gated by Rst_n so nothing leaks onto the read buses while in reset.
        else if (Rst_n && commit && (rd_addr[gi] == Rw)) rd_data[gi] = busW;
`endif
      end
    end
  endgenerate

endmodule
